// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first over WIDTH cycles,
// with a per-cycle serial bit stream and a held parallel result plus borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             bit_out,
  output logic             bit_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_s;
  logic             br_next_s;
  logic             last_s;

  function automatic logic sub_bit(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic sub_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  // Full-subtractor slice on the operand LSBs and the running borrow.
  always_comb begin
    d_s       = sub_bit(a_q[0], b_q[0], br_q);
    br_next_s = sub_borrow(a_q[0], b_q[0], br_q);
    last_s    = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_s, res_q[WIDTH-1:1]};
        br_d  = br_next_s;
        // The final bit lands in the result and the outputs on the same edge.
        if (last_s) begin
          state_d  = S_DONE;
          diff_d   = {d_s, res_q[WIDTH-1:1]};
          borrow_d = br_next_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign bit_valid = (state_q == S_RUN);
  assign bit_out   = (state_q == S_RUN) & d_s;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: cycle model for WIDTH=8 checked every
// cycle, hand-computed vectors, and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, bit_out, bit_valid;
  logic [W-1:0] diff;

  logic         start4 = 1'b0;
  logic [3:0]   a4 = 4'd0;
  logic [3:0]   b4 = 4'd0;
  logic         busy4, done4, borrow4, bit_out4, bit_valid4;
  logic [3:0]   diff4;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .bit_out(bit_out), .bit_valid(bit_valid)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4),
    .bit_out(bit_out4), .bit_valid(bit_valid4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1..W run cycle index, W+1 done.
  int           m_phase = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_diff = '0;
  logic         m_borrow = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_a <= '0; m_b <= '0; m_diff <= '0; m_borrow <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1; m_a <= a; m_b <= b;
      end
    end else if (m_phase <= W) begin
      m_phase <= m_phase + 1;
      if (m_phase == W) begin
        m_diff   <= m_a - m_b;
        m_borrow <= (m_a < m_b);
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] full;
    logic         run;
    full = m_a - m_b;
    run  = (m_phase >= 1) && (m_phase <= W);
    check("busy", {31'd0, busy}, {31'd0, run});
    check("bit_valid", {31'd0, bit_valid}, {31'd0, run});
    check("done", {31'd0, done}, {31'd0, m_phase == W + 1});
    check("bit_out", {31'd0, bit_out}, {31'd0, run ? full[m_phase - 1] : 1'b0});
    check("diff", {24'd0, diff}, {24'd0, m_diff});
    check("borrow", {31'd0, borrow}, {31'd0, m_borrow});
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ediff, input logic eb);
    int lat = 0;
    int nb = 0;
    logic [W-1:0] ser = '0;
    start = 1'b1; a = ta; b = tb_v;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = ~ta; b = ~tb_v;
      end
      if (bit_valid) begin
        if (nb < W) ser[nb] = bit_out;
        nb++;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check("op_latency", lat, W + 1);
    check("op_nbits", nb, W);
    check("op_serial", {24'd0, ser}, {24'd0, ediff});
    check("op_diff", {24'd0, diff}, {24'd0, ediff});
    check("op_borrow", {31'd0, borrow}, {31'd0, eb});
    @(negedge clk);
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v);
    int lat = 0;
    int nv = 0;
    logic [3:0] ser = 4'd0;
    logic [3:0] e;
    e = ta - tb_v;
    start4 = 1'b1; a4 = ta; b4 = tb_v;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start4 = 1'b0;
      if (bit_valid4) begin
        if (nv < 4) ser[nv] = bit_out4;
        nv++;
      end
      if (done4) begin
        lat = k;
        break;
      end
    end
    check("w4_latency", lat, 5);
    check("w4_diff", {28'd0, diff4}, {28'd0, e});
    check("w4_borrow", {31'd0, borrow4}, {31'd0, ta < tb_v});
    check("w4_serial", {28'd0, ser}, {28'd0, e});
    check("w4_busy_in_done", {31'd0, busy4}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    int lat;
    int dt[3];
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd5, 8'd3, 8'd2, 1'b0);
    run_op(8'd3, 8'd5, 8'hFE, 1'b1);
    run_op(8'd0, 8'd1, 8'hFF, 1'b1);
    run_op(8'd255, 8'd255, 8'd0, 1'b0);

    // Start re-pulsed mid-run must be ignored.
    ndone = 0; lat = 0;
    start = 1'b1; a = 8'd200; b = 8'd77;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        start = 1'b1; a = 8'd9; b = 8'd9;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        ndone++; lat = k;
      end
    end
    check("repulse_ndone", ndone, 1);
    check("repulse_latency", lat, W + 1);
    check("repulse_diff", {24'd0, diff}, 32'd123);

    // Reset in RUN cycle 4 aborts; start during reset is ignored.
    start = 1'b1; a = 8'hA5; b = 8'h0F;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    #2 rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_diff_held", {24'd0, diff}, 32'd0);
    run_op(8'd100, 8'd58, 8'd42, 1'b0);

    // Start held high: three back-to-back operations.
    ndone = 0;
    start = 1'b1; a = 8'd17; b = 8'd200;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 3) dt[ndone] = k;
        ndone++;
      end
      if (k == 30) start = 1'b0;
    end
    check("b2b_ndone", ndone, 3);
    check("b2b_first", dt[0], W + 1);
    check("b2b_gap1", dt[1] - dt[0], W + 2);
    check("b2b_gap2", dt[2] - dt[1], W + 2);
    check("b2b_diff", {24'd0, diff}, 32'd73);
    check("b2b_borrow", {31'd0, borrow}, 32'd1);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run4(4'(i), 4'(j));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, unsigned; captured on the accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, unsigned; captured on the accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress (RUN state).
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1 bit: final borrow-out, 1 iff a < b (unsigned).
REQ-011 The block SHALL have port bit_out, output, 1 bit: serial difference bit produced in the current RUN cycle, LSB first.
REQ-012 The block SHALL have port bit_valid, output, 1 bit: high for each RUN cycle in which bit_out is meaningful.

Function
REQ-013 The block SHALL implement a three-state FSM:
  - IDLE -> RUN on start=1; a and b are captured into shift registers, and the borrow flop and bit counter are cleared.
  - RUN -> DONE after exactly WIDTH RUN cycles.
  - DONE -> IDLE unconditionally after one cycle.
REQ-014 In each RUN cycle, the block SHALL use a0 = LSB of the minuend shift register, b0 = LSB of the subtrahend shift register, and br = borrow flop, and SHALL compute d = a0 ^ b0 ^ br and br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 Each RUN cycle, the block SHALL shift both operand registers right by one, shift d into the MSB of the result register (shifting right), and load br_next into the borrow flop.
REQ-016 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide, SHALL count 0..WIDTH-1 in RUN, and SHALL NOT wrap within one operation.
REQ-017 bit_out and bit_valid SHALL be combinational from RUN state and d: bit_valid=1 exactly WIDTH cycles per operation, with bit i appearing in the i-th RUN cycle.
REQ-018 On entry to DONE, diff SHALL equal the full result register and borrow SHALL equal the final borrow flop, and done=1 for exactly that one cycle.
REQ-019 diff and borrow SHALL hold their values from DONE until the next accepted start; during RUN they SHALL keep the previous result and SHALL NOT expose partial values.
REQ-020 Latency SHALL be WIDTH+1 cycles from the clock edge accepting start to done=1.
REQ-021 start in RUN or DONE SHALL be ignored; it SHALL NOT be queued, and the operands SHALL NOT be re-captured.
REQ-022 start held high continuously SHALL produce back-to-back operations, each of WIDTH+2 cycles (IDLE accept, WIDTH RUN, DONE).
REQ-023 Changes on a and b after acceptance SHALL NOT affect the operation in progress.
REQ-024 busy SHALL equal (state == RUN); done SHALL equal (state == DONE).

Reset
REQ-025 On rst=1, the block SHALL force the following immediately, independent of clk:
  - state=IDLE, busy=0, done=0, diff=0, borrow=0, bit_out=0, bit_valid=0;
  - counter, borrow flop and operand registers cleared.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start accepted after rst deasserts SHALL begin a fresh operation.
REQ-027 start SHALL be ignored while rst=1.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover: a=5, b=3, start pulse -> bit_valid for 8 cycles, serial bits 0,1,0,0,0,0,0,0; done at cycle 9; diff=2, borrow=0.
REQ-029 The bench SHALL cover: a=3, b=5 -> diff=254 (0xFE), borrow=1; a=0, b=1 -> diff=255, borrow=1; a=255, b=255 -> diff=0, borrow=0.
REQ-030 The bench SHALL cover: start re-pulsed at RUN cycle 3 with a=9, b=9 -> ignored, result of the original operands delivered, exactly one done pulse.
REQ-031 The bench SHALL cover: rst asserted at RUN cycle 4 -> busy, done, diff and borrow all 0 immediately; no done pulse; then a=100, b=58 -> diff=42, borrow=0.
REQ-032 The bench SHALL cover: start held high for three operations -> done pulses spaced exactly 10 cycles apart.
REQ-033 The bench SHALL cover: exhaustive WIDTH=4 sweep of all 256 (a,b) pairs -> diff==(a-b) mod 16 and borrow==(a<b) for every pair.
